// File: rtl/alarm_trigger.sv
// Alarm trigger: compares the running time against the stored alarm, drives the buzzer,
// and handles snooze, stop and ring timeout. All logic runs on the divided clock.
module alarm_trigger #(
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_alarm,
    input  logic       sec_tick,
    input  logic [4:0] time_hour,
    input  logic [5:0] time_min,
    input  logic [5:0] time_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       snooze,
    input  logic       stop,
    output logic       alarm_ring,
    output logic       buzzer,
    output logic [1:0] snooze_count,
    output logic [1:0] alarm_state
);

    localparam int unsigned TimerWidth = $clog2(RING_SECONDS);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2
    } state_e;

    state_e                state;
    logic [TimerWidth-1:0] ring_timer;
    logic                  beep_phase;
    logic [4:0]            tgt_hour;
    logic [5:0]            tgt_min;

    logic       at_second_zero;
    logic       alarm_match;
    logic       snooze_match;
    logic [6:0] snooze_sum;
    logic       snooze_wrap;
    logic [5:0] snooze_min_next;
    logic [4:0] snooze_hour_next;
    logic       snooze_allowed;
    logic       ring_timeout;

    // Match conditions, snooze target arithmetic and ring timeout detection
    always_comb begin
        at_second_zero   = sec_tick && (time_sec == 6'd0);
        alarm_match      = at_second_zero && (time_hour == alarm_hour) && (time_min == alarm_min);
        snooze_match     = at_second_zero && (time_hour == tgt_hour) && (time_min == tgt_min);
        // 7-bit sum so minute overflow is seen before any truncation
        snooze_sum       = {1'b0, time_min} + 7'(SNOOZE_MIN);
        snooze_wrap      = (snooze_sum >= 7'd60);
        snooze_min_next  = snooze_wrap ? 6'(snooze_sum - 7'd60) : snooze_sum[5:0];
        if (!snooze_wrap) begin
            snooze_hour_next = time_hour;
        end else if (time_hour == 5'd23) begin
            snooze_hour_next = 5'd0;
        end else begin
            snooze_hour_next = time_hour + 5'd1;
        end
        snooze_allowed   = (snooze_count < 2'(MAX_SNOOZE));
        ring_timeout     = sec_tick && (ring_timer == TimerWidth'(RING_SECONDS - 1));
    end

    // Alarm state machine with registered ring/buzzer outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            alarm_ring   <= 1'b0;
            buzzer       <= 1'b0;
            snooze_count <= 2'd0;
            ring_timer   <= '0;
            beep_phase   <= 1'b0;
            tgt_hour     <= 5'd0;
            tgt_min      <= 6'd0;
        end else if (!enable_alarm) begin
            state        <= StIdle;
            alarm_ring   <= 1'b0;
            buzzer       <= 1'b0;
            snooze_count <= 2'd0;
            ring_timer   <= '0;
            beep_phase   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // Buttons are ignored here; a match always starts the ring
                    if (alarm_match) begin
                        state      <= StRing;
                        alarm_ring <= 1'b1;
                        buzzer     <= 1'b1;
                        ring_timer <= '0;
                        beep_phase <= 1'b1;
                    end
                end
                StRing: begin
                    // Snooze beyond the allowance behaves exactly like stop
                    if (stop || (snooze && !snooze_allowed) || (!snooze && ring_timeout)) begin
                        state        <= StIdle;
                        alarm_ring   <= 1'b0;
                        buzzer       <= 1'b0;
                        beep_phase   <= 1'b0;
                        snooze_count <= 2'd0;
                    end else if (snooze) begin
                        state        <= StSnooze;
                        alarm_ring   <= 1'b0;
                        buzzer       <= 1'b0;
                        beep_phase   <= 1'b0;
                        snooze_count <= snooze_count + 2'd1;
                        tgt_hour     <= snooze_hour_next;
                        tgt_min      <= snooze_min_next;
                    end else if (sec_tick) begin
                        ring_timer <= ring_timer + 1'b1;
                        beep_phase <= ~beep_phase;
                        buzzer     <= ~beep_phase;
                    end
                end
                StSnooze: begin
                    if (stop) begin
                        state        <= StIdle;
                        snooze_count <= 2'd0;
                    end else if (snooze_match) begin
                        state      <= StRing;
                        alarm_ring <= 1'b1;
                        buzzer     <= 1'b1;
                        ring_timer <= '0;
                        beep_phase <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    alarm_ring <= 1'b0;
                    buzzer     <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_state = state;

endmodule
